// File: rtl/intc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : intc_pkg
//  Description : Shared constants and helpers for the interrupt-controller
//                ISR vector table (default base address, control-word bit
//                positions, constant-foldable ceil(log2)).
//  Revision    : 1.0 - initial release
// ============================================================================
package intc_pkg;

    // Default byte address of ISR vector slot 0
    localparam logic [31:0] INTC_BASE_ADDR   = 32'h0002_0000;

    // Control-word bit positions
    localparam int          CTRL_LOCK_BIT    = 0;
    localparam int          CTRL_CLR_ERR_BIT = 1;

    // ceil(log2(value)); returns 0 for value <= 1
    function automatic int clog2(input int value);
        int result;
        int rem;
        result = 0;
        rem    = value - 1;
        while (rem > 0) begin
            result = result + 1;
            rem    = rem >> 1;
        end
        return result;
    endfunction

endpackage : intc_pkg
`default_nettype wire

// File: rtl/isr_addr_decode.sv
`default_nettype none
// ============================================================================
//  Module      : isr_addr_decode
//  Description : Combinational decode of a configuration byte address into
//                range/alignment flags, a control-word flag and a slot index.
//                Slots occupy BASE_ADDR + 4k (k < N_CH); the control word sits
//                directly after the last slot.
//  Revision    : 1.0 - initial release
// ============================================================================
module isr_addr_decode
    import intc_pkg::*;
#(
    parameter int                N_CH      = 4,
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(INTC_BASE_ADDR),
    parameter int                IDX_W     = clog2(N_CH + 1)
) (
    input  logic [ADDR_W-1:0] addr,
    output logic              in_range,
    output logic              aligned,
    output logic              is_ctrl,
    output logic [IDX_W-1:0]  idx
);

    // Byte span of the decoded window: N_CH slots plus the control word
    localparam logic [ADDR_W-1:0] c_SPAN = ADDR_W'(4 * (N_CH + 1));

    logic [ADDR_W-1:0] w_off;

    // Offset from the base; wraps for addresses below the base, which the
    // explicit lower-bound compare rejects
    assign w_off    = addr - BASE_ADDR;
    assign in_range = (addr >= BASE_ADDR) && (w_off < c_SPAN);
    assign aligned  = (addr[1:0] == 2'b00);
    // Word index compared at full width so out-of-window offsets cannot alias
    assign is_ctrl  = (w_off[ADDR_W-1:2] == (ADDR_W-2)'(N_CH));
    assign idx      = w_off[IDX_W+1:2];

endmodule : isr_addr_decode
`default_nettype wire

// File: rtl/isr_vector_table.sv
`default_nettype none
// ============================================================================
//  Module      : isr_vector_table
//  Description : Parametrised ISR vector register bank. CPU configuration
//                writes program N_CH vector slots and a control word (lock,
//                error clear). Bad writes raise a sticky error that keeps the
//                first offending address. The interrupt arbiter gets one
//                registered lookup per cycle with read-before-write semantics.
//  Revision    : 1.0 - initial release
// ============================================================================
module isr_vector_table
    import intc_pkg::*;
#(
    parameter int                N_CH      = 4,
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] BASE_ADDR = ADDR_W'(INTC_BASE_ADDR),
    parameter int                ID_W      = (N_CH > 1) ? clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] intc_write_address,
    input  logic [DATA_W-1:0] intc_write_data,
    input  logic              write_enable,
    input  logic              lookup_req,
    input  logic [ID_W-1:0]   lookup_id,
    output logic              lookup_ack,
    output logic [DATA_W-1:0] lookup_vector,
    output logic              lookup_hit,
    output logic [N_CH-1:0]   vector_valid,
    output logic              locked,
    output logic              cfg_error,
    output logic [ADDR_W-1:0] cfg_error_addr
);

    // Index must reach N_CH itself, which addresses the control word
    localparam int c_IDX_W = clog2(N_CH + 1);

    // ------------------------------------------------------------------
    // Address decode
    // ------------------------------------------------------------------
    logic               w_in_range;
    logic               w_aligned;
    logic               w_is_ctrl;
    logic [c_IDX_W-1:0] w_idx;

    isr_addr_decode #(
        .N_CH      (N_CH),
        .ADDR_W    (ADDR_W),
        .BASE_ADDR (BASE_ADDR),
        .IDX_W     (c_IDX_W)
    ) u_decode (
        .addr     (intc_write_address),
        .in_range (w_in_range),
        .aligned  (w_aligned),
        .is_ctrl  (w_is_ctrl),
        .idx      (w_idx)
    );

    // ------------------------------------------------------------------
    // Write classification
    // ------------------------------------------------------------------
    logic r_locked;
    logic r_err;
    logic [ADDR_W-1:0] r_err_addr;

    logic w_addr_ok;
    logic w_ctrl_wr;
    logic w_slot_wr;
    logic w_err_evt;

    assign w_addr_ok = write_enable && w_in_range && w_aligned;
    // Control word stays writable after lock so the error can still be cleared
    assign w_ctrl_wr = w_addr_ok && w_is_ctrl;
    assign w_slot_wr = w_addr_ok && !w_is_ctrl && !r_locked;
    // Anything written that is neither a control write nor an accepted slot
    // write (bad address, misaligned, or slot write while locked)
    assign w_err_evt = write_enable && !(w_ctrl_wr || w_slot_wr);

    // ------------------------------------------------------------------
    // Vector storage, one register slot per channel
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] w_vec [N_CH];
    logic [N_CH-1:0]   w_vld;

    generate
        for (genvar k = 0; k < N_CH; k++) begin : g_slot
            logic [DATA_W-1:0] r_vec;
            logic              r_vld;

            // Capture the vector and mark the slot programmed on an accepted write
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    r_vec <= '0;
                    r_vld <= 1'b0;
                end else if (w_slot_wr && (w_idx == c_IDX_W'(k))) begin
                    r_vec <= intc_write_data;
                    r_vld <= 1'b1;
                end
            end

            assign w_vec[k] = r_vec;
            assign w_vld[k] = r_vld;
        end
    endgenerate

    assign vector_valid = w_vld;

    // ------------------------------------------------------------------
    // Lock and error status
    // ------------------------------------------------------------------

    // One-way lock: only reset returns the table to the unlocked state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_locked <= 1'b0;
        end else if (w_ctrl_wr && intc_write_data[CTRL_LOCK_BIT]) begin
            r_locked <= 1'b1;
        end
    end

    // Sticky error keeping the first bad address; a control write may clear it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end else if (w_err_evt) begin
            r_err <= 1'b1;
            if (!r_err) begin
                r_err_addr <= intc_write_address;
            end
        end else if (w_ctrl_wr && intc_write_data[CTRL_CLR_ERR_BIT]) begin
            r_err      <= 1'b0;
            r_err_addr <= '0;
        end
    end

    assign locked         = r_locked;
    assign cfg_error      = r_err;
    assign cfg_error_addr = r_err_addr;

    // ------------------------------------------------------------------
    // Lookup pipeline
    // ------------------------------------------------------------------
    // One extra bit keeps the id compare meaningful when N_CH is a power of two
    logic [ID_W:0]     w_id_ext;
    logic [DATA_W-1:0] w_rd_vec;
    logic              w_rd_hit;
    logic              r_ack;
    logic [DATA_W-1:0] r_vec_out;
    logic              r_hit;

    assign w_id_ext = {1'b0, lookup_id};

    // Select the requested slot from the pre-edge storage; unmatched ids read 0
    always_comb begin
        w_rd_vec = '0;
        w_rd_hit = 1'b0;
        for (int k = 0; k < N_CH; k++) begin
            if (w_id_ext == (ID_W + 1)'(k)) begin
                w_rd_vec = w_vec[k];
                w_rd_hit = w_vld[k];
            end
        end
    end

    // Register the lookup result; data and hit hold between requests
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ack     <= 1'b0;
            r_vec_out <= '0;
            r_hit     <= 1'b0;
        end else if (lookup_req) begin
            r_ack     <= 1'b1;
            r_vec_out <= w_rd_vec;
            r_hit     <= w_rd_hit;
        end else begin
            r_ack     <= 1'b0;
        end
    end

    assign lookup_ack    = r_ack;
    assign lookup_vector = r_vec_out;
    assign lookup_hit    = r_hit;

endmodule : isr_vector_table
`default_nettype wire
